// File: rtl/rv_pkg.sv
// Shared RV core definitions: data-memory geometry, arbiter state encoding
// and the request bundle used by every data-memory requester.
package rv_pkg;

    localparam int XLEN          = 32;
    localparam int DMEM_ADDR_BIT = 12;
    localparam int DMEM_SIZE     = 1 << DMEM_ADDR_BIT;
    localparam int DMEM_WADDR_W  = DMEM_ADDR_BIT - 2;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [DMEM_WADDR_W-1:0] addr;
        logic                    wen;
        logic [XLEN/8-1:0]       wstrb;
        logic [XLEN-1:0]         wdata;
    } dmem_req_t;

endpackage

// File: rtl/rv_dmem_arbiter.sv
// Shares the single-port data memory between the core (C) and debug/loader (D)
// ports: core priority with a starvation bound, D lock for bursts, 1-cycle read response.
module rv_dmem_arbiter
    import rv_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                     i_arb_clk,
    input  logic                     i_arb_rstn,

    input  logic                     i_c_req,
    output logic                     o_c_gnt,
    input  logic [DMEM_ADDR_BIT-3:0] i_c_addr,
    input  logic                     i_c_wen,
    input  logic [XLEN/8-1:0]        i_c_wstrb,
    input  logic [XLEN-1:0]          i_c_wdata,
    output logic                     o_c_rvalid,
    output logic [XLEN-1:0]          o_c_rdata,

    input  logic                     i_d_req,
    output logic                     o_d_gnt,
    input  logic [DMEM_ADDR_BIT-3:0] i_d_addr,
    input  logic                     i_d_wen,
    input  logic [XLEN/8-1:0]        i_d_wstrb,
    input  logic [XLEN-1:0]          i_d_wdata,
    output logic                     o_d_rvalid,
    output logic [XLEN-1:0]          o_d_rdata,
    input  logic                     i_d_lock,

    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic                     o_dmem_wen,
    output logic [XLEN/8-1:0]        o_dmem_wstrb,
    output logic [XLEN-1:0]          o_dmem_wdata,
    input  logic [XLEN-1:0]          i_dmem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             c_win;
    logic             d_win;
    dmem_req_t        c_bus;
    dmem_req_t        d_bus;
    dmem_req_t        mem_bus;

    assign c_bus   = '{addr: i_c_addr, wen: i_c_wen, wstrb: i_c_wstrb, wdata: i_c_wdata};
    assign d_bus   = '{addr: i_d_addr, wen: i_d_wen, wstrb: i_d_wstrb, wdata: i_d_wdata};
    assign starved = (starve_cnt >= CNT_W'(STARVE_MAX));

    // Grants are gated by reset so nothing reaches the memory while it is asserted.
    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (i_arb_rstn) begin
            if (state == ARB_LOCK) begin
                d_win = i_d_req;
            end else if (i_c_req && (!starved || !i_d_req)) begin
                c_win = 1'b1;
            end else begin
                d_win = i_d_req;
            end
        end
    end

    always_comb begin
        mem_bus       = c_bus;
        mem_bus.wen   = 1'b0;
        mem_bus.wstrb = '0;
        if (d_win) begin
            mem_bus = d_bus;
        end else if (c_win) begin
            mem_bus = c_bus;
        end
        if (!i_arb_rstn) begin
            mem_bus = '0;
        end
    end

    assign o_c_gnt      = c_win;
    assign o_d_gnt      = d_win;
    assign o_dmem_addr  = mem_bus.addr;
    assign o_dmem_wen   = mem_bus.wen;
    assign o_dmem_wstrb = mem_bus.wstrb;
    assign o_dmem_wdata = mem_bus.wdata;

    always_ff @(posedge i_arb_clk or negedge i_arb_rstn) begin
        if (!i_arb_rstn) begin
            state      <= ARB_FREE;
            starve_cnt <= '0;
            o_c_rvalid <= 1'b0;
            o_d_rvalid <= 1'b0;
            o_c_rdata  <= '0;
            o_d_rdata  <= '0;
        end else begin
            case (state)
                ARB_FREE: if (d_win && i_d_lock) state <= ARB_LOCK;
                ARB_LOCK: if (!i_d_lock) state <= ARB_FREE;
                default:  state <= ARB_FREE;
            endcase

            // Counts core wins that pushed a waiting D request back.
            if (d_win || !i_d_req) begin
                starve_cnt <= '0;
            end else if (c_win && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            o_c_rvalid <= c_win && !i_c_wen;
            o_d_rvalid <= d_win && !i_d_wen;
            if (c_win && !i_c_wen) o_c_rdata <= i_dmem_rdata;
            if (d_win && !i_d_wen) o_d_rdata <= i_dmem_rdata;
        end
    end

endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Directed bench for rv_dmem_arbiter with a byte-strobed memory model.
module tb_rv_dmem_arbiter;
    import rv_pkg::*;

    localparam int AW = DMEM_ADDR_BIT - 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              c_req, c_gnt, c_wen, c_rvalid;
    logic [AW-1:0]     c_addr;
    logic [XLEN/8-1:0] c_wstrb;
    logic [XLEN-1:0]   c_wdata, c_rdata;
    logic              d_req, d_gnt, d_wen, d_rvalid, d_lock;
    logic [AW-1:0]     d_addr;
    logic [XLEN/8-1:0] d_wstrb;
    logic [XLEN-1:0]   d_wdata, d_rdata;
    logic [AW-1:0]     dmem_addr;
    logic              dmem_wen;
    logic [XLEN/8-1:0] dmem_wstrb;
    logic [XLEN-1:0]   dmem_wdata, dmem_rdata;

    logic [XLEN-1:0]   mem [0:(1<<AW)-1];
    logic              pre_en = 1'b0;
    logic [AW-1:0]     pre_addr = '0;
    logic [XLEN-1:0]   pre_data = '0;

    int n_chk = 0;
    int n_pass = 0;

    rv_dmem_arbiter #(.STARVE_MAX(4)) dut (
        .i_arb_clk(clk), .i_arb_rstn(rstn),
        .i_c_req(c_req), .o_c_gnt(c_gnt), .i_c_addr(c_addr), .i_c_wen(c_wen),
        .i_c_wstrb(c_wstrb), .i_c_wdata(c_wdata), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_d_req(d_req), .o_d_gnt(d_gnt), .i_d_addr(d_addr), .i_d_wen(d_wen),
        .i_d_wstrb(d_wstrb), .i_d_wdata(d_wdata), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .i_d_lock(d_lock),
        .o_dmem_addr(dmem_addr), .o_dmem_wen(dmem_wen), .o_dmem_wstrb(dmem_wstrb),
        .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (dmem_wen) begin
            for (int b = 0; b < XLEN/8; b++)
                if (dmem_wstrb[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle();
        c_req = 1'b0; c_wen = 1'b0; c_addr = '0; c_wstrb = '0; c_wdata = '0;
        d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wstrb = '0; d_wdata = '0; d_lock = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [XLEN-1:0] v);
        pre_en = 1'b1; pre_addr = a; pre_data = v;
        tick();
        pre_en = 1'b0;
    endtask

    initial begin
        logic [9:0] d_turn;
        idle();
        preload(AW'(32'h10), 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) preload(AW'(32'h20 + k), 32'h55555555);
        preload(AW'(32'h30), 32'h11223344);
        for (int k = 0; k < 6; k++) preload(AW'(32'h40 + k), 32'hA0000000 + k);
        preload(AW'(32'h50), 32'h00000000);

        // Reset state, with a core request present to show grants are held off.
        c_req = 1'b1; c_addr = AW'(32'h10); c_wstrb = 4'hF;
        #1;
        check("rst_c_gnt", 32'(c_gnt), 0);
        check("rst_d_gnt", 32'(d_gnt), 0);
        check("rst_dmem_wen", 32'(dmem_wen), 0);
        check("rst_dmem_addr", 32'(dmem_addr), 0);
        check("rst_dmem_wstrb", 32'(dmem_wstrb), 0);
        check("rst_c_rvalid", 32'(c_rvalid), 0);
        check("rst_d_rvalid", 32'(d_rvalid), 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_state", 32'(dut.state), 32'(ARB_FREE));
        idle();
        @(negedge clk); rstn = 1'b1;
        tick();

        // 1: single core read
        c_req = 1'b1; c_addr = AW'(32'h10);
        #1;
        check("t1_c_gnt", 32'(c_gnt), 1);
        check("t1_d_gnt", 32'(d_gnt), 0);
        check("t1_dmem_addr", 32'(dmem_addr), 32'h10);
        check("t1_dmem_wen", 32'(dmem_wen), 0);
        tick();
        c_req = 1'b0;
        check("t1_c_rvalid", 32'(c_rvalid), 1);
        check("t1_c_rdata", c_rdata, 32'hDEADBEEF);
        check("t1_d_rvalid", 32'(d_rvalid), 0);
        tick();
        check("t1_rvalid_pulse", 32'(c_rvalid), 0);
        check("t1_rdata_hold", c_rdata, 32'hDEADBEEF);

        // 2: both ports request continuously -> C,C,C,C,D repeating
        d_turn = 10'b1000010000;
        c_req = 1'b1; c_addr = AW'(32'h10);
        d_req = 1'b1; d_addr = AW'(32'h30);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t2_c_gnt", 32'(c_gnt), 32'(!d_turn[i]));
            check("t2_d_gnt", 32'(d_gnt), 32'(d_turn[i]));
            if (i == 2) check("t2_starve_cnt", 32'(dut.starve_cnt), 2);
            tick();
            check("t2_c_rvalid", 32'(c_rvalid), 32'(!d_turn[i]));
            check("t2_d_rvalid", 32'(d_rvalid), 32'(d_turn[i]));
        end
        idle();

        // 3: locked D write burst while the core waits
        d_req = 1'b1; d_wen = 1'b1; d_lock = 1'b1; d_addr = AW'(32'h20);
        d_wstrb = 4'b0011; d_wdata = 32'h0000AAAA;
        #1;
        check("t3_d_gnt0", 32'(d_gnt), 1);
        check("t3_dmem_wen", 32'(dmem_wen), 1);
        check("t3_dmem_wstrb", 32'(dmem_wstrb), 32'h3);
        tick();
        check("t3_state_lock", 32'(dut.state), 32'(ARB_LOCK));
        check("t3_no_d_rvalid", 32'(d_rvalid), 0);
        c_req = 1'b1; c_addr = AW'(32'h10);
        for (int k = 1; k < 3; k++) begin
            d_addr = AW'(32'h20 + k);
            #1;
            check("t3_c_stall", 32'(c_gnt), 0);
            check("t3_d_gnt", 32'(d_gnt), 1);
            check("t3_dmem_addr", 32'(dmem_addr), 32'h20 + k);
            tick();
        end
        d_req = 1'b0; d_wen = 1'b0; d_lock = 1'b0;
        #1;
        check("t3_release_stall", 32'(c_gnt), 0);
        tick();
        check("t3_state_free", 32'(dut.state), 32'(ARB_FREE));
        #1;
        check("t3_c_gnt_after", 32'(c_gnt), 1);
        tick();
        c_req = 1'b0;
        check("t3_c_rvalid", 32'(c_rvalid), 1);
        check("t3_c_rdata", c_rdata, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) check("t3_mem", mem[AW'(32'h20 + k)], 32'h5555AAAA);

        // 4: core byte-strobed write then readback
        c_req = 1'b1; c_wen = 1'b1; c_addr = AW'(32'h30);
        c_wstrb = 4'b0100; c_wdata = 32'h00FF0000;
        #1;
        check("t4_c_gnt", 32'(c_gnt), 1);
        check("t4_dmem_wen", 32'(dmem_wen), 1);
        check("t4_dmem_wstrb", 32'(dmem_wstrb), 32'h4);
        check("t4_dmem_wdata", dmem_wdata, 32'h00FF0000);
        tick();
        check("t4_no_rvalid", 32'(c_rvalid), 0);
        c_wen = 1'b0;
        tick();
        c_req = 1'b0;
        check("t4_rb_rvalid", 32'(c_rvalid), 1);
        check("t4_rb_rdata", c_rdata, 32'h11FF3344);

        // 6: alternating core / debug reads
        idle();
        for (int i = 0; i < 6; i++) begin
            c_req = (i % 2 == 0);
            d_req = (i % 2 == 1);
            c_addr = AW'(32'h40 + i);
            d_addr = AW'(32'h40 + i);
            #1;
            check("t6_c_gnt", 32'(c_gnt), 32'(i % 2 == 0));
            check("t6_d_gnt", 32'(d_gnt), 32'(i % 2 == 1));
            tick();
            check("t6_c_rvalid", 32'(c_rvalid), 32'(i % 2 == 0));
            check("t6_d_rvalid", 32'(d_rvalid), 32'(i % 2 == 1));
            if (i % 2 == 0) check("t6_c_rdata", c_rdata, 32'hA0000000 + i);
            else            check("t6_d_rdata", d_rdata, 32'hA0000000 + i);
        end
        idle();
        tick();

        // 5: reset asserted mid-burst, the cycle after a locked D read grant
        d_req = 1'b1; d_lock = 1'b1; d_addr = AW'(32'h10);
        #1;
        check("t5_d_gnt_read", 32'(d_gnt), 1);
        tick();
        check("t5_state_lock", 32'(dut.state), 32'(ARB_LOCK));
        c_req = 1'b1; c_addr = AW'(32'h10);
        d_wen = 1'b1; d_addr = AW'(32'h50); d_wstrb = 4'hF; d_wdata = 32'h12345678;
        #1;
        check("t5_dmem_wen_pre", 32'(dmem_wen), 1);
        #1;
        rstn = 1'b0;
        #1;
        check("t5_dmem_wen_async", 32'(dmem_wen), 0);
        check("t5_d_gnt_async", 32'(d_gnt), 0);
        check("t5_c_gnt_async", 32'(c_gnt), 0);
        check("t5_dmem_addr_async", 32'(dmem_addr), 0);
        check("t5_d_rvalid_async", 32'(d_rvalid), 0);
        check("t5_state_free", 32'(dut.state), 32'(ARB_FREE));
        check("t5_starve_cnt", 32'(dut.starve_cnt), 0);
        tick();
        check("t5_no_write", mem[AW'(32'h50)], 32'h00000000);
        idle();
        @(negedge clk); rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t5_d_rvalid_after", 32'(d_rvalid), 0);
            check("t5_c_rvalid_after", 32'(c_rvalid), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
